// File: rtl/rgb_mixer_if.sv
// Tiny Tapeout tile pin bundle for rgb_mixer.
// There is no valid/ready handshake on these pins. Every signal is a plain level:
// the encoder lines are asynchronous to clk and are synchronized inside the tile.
// The tile outputs are registered and may be sampled at any time away from the
// rising edge of clk.
interface rgb_mixer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // The harness drives the tile inputs and observes the outputs.
  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  // The tile consumes the inputs and drives the outputs.
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/rgb_mixer.sv
// rgb_mixer: three quadrature encoders set three 8-bit saturating levels.
// Each level drives one PWM output, and all three outputs share one free-running counter.
// Each encoder line passes through three stages: a 2-flop synchronizer, an
// all-equal window debounce, and x1 decode on the rising edge of A.
// Optional macro RGB_MIXER_DEBUG_EN drives uio_out with a registered view of the
// level selected by ui_in[7:6] (3 selects pwm_cnt) and sets uio_oe to 0xFF.
// When the macro is undefined, both buses stay at 0.
module rgb_mixer #(
  parameter int DEBOUNCE_LEN = 8
) (
  input logic       clk,
  input logic       rst_n,
  rgb_mixer_if.slave tt
);

  // Line index 2*c is channel c's A line, and 2*c+1 is its B line.
  logic [5:0]              s1;
  logic [5:0]              s2;
  logic [DEBOUNCE_LEN-2:0] hist [6];
  logic [DEBOUNCE_LEN-1:0] win  [6];
  logic [5:0]              deb;
  logic [2:0]              deb_a_d;
  logic [2:0]              rise;
  logic [7:0]              level [3];
  logic [7:0]              pwm_cnt;
  logic [2:0]              pwm;

  // Two-flop synchronizer on the six encoder lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= tt.ui_in[5:0];
      s2 <= s1;
    end
  end

  // The debounce window is the current s2 plus the previous DEBOUNCE_LEN-1 samples.
  // Because the newest sample comes straight from s2, the debounced line changes
  // DEBOUNCE_LEN+2 edges after the pin changes.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      win[i] = {hist[i], s2[i]};
    end
  end

  // Sample history, and a debounced line that moves only when the whole window agrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        hist[i] <= '0;
      end
      deb <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        hist[i] <= win[i][DEBOUNCE_LEN-2:0];
        if (&win[i]) begin
          deb[i] <= 1'b1;
        end else if (~|win[i]) begin
          deb[i] <= 1'b0;
        end
      end
    end
  end

  // Rising edge of the debounced A line, one pulse per detent.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      rise[c] = deb[2*c] & ~deb_a_d[c];
    end
  end

  // Delay debounced A for edge detection and step the saturating levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_a_d <= '0;
      for (int c = 0; c < 3; c++) begin
        level[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        deb_a_d[c] <= deb[2*c];
        if (rise[c]) begin
          if (!deb[2*c+1] && level[c] != 8'd255) begin
            level[c] <= level[c] + 8'd1;
          end else if (deb[2*c+1] && level[c] != 8'd0) begin
            level[c] <= level[c] - 8'd1;
          end
        end
      end
    end
  end

  // Shared 256-clock PWM period; a level L is high while the counter is below L.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      for (int c = 0; c < 3; c++) begin
        pwm[c] <= (pwm_cnt < level[c]);
      end
    end
  end

  assign tt.uo_out = {5'b00000, pwm};

`ifdef RGB_MIXER_DEBUG_EN
  logic [7:0] dbg_q;
  logic [7:0] oe_q;
  logic       unused_ok;

  // Registered debug view: ui_in[7:6] picks a level, or pwm_cnt when it is 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_q <= '0;
      oe_q  <= '0;
    end else begin
      oe_q <= 8'hFF;
      case (tt.ui_in[7:6])
        2'd0:    dbg_q <= level[0];
        2'd1:    dbg_q <= level[1];
        2'd2:    dbg_q <= level[2];
        default: dbg_q <= pwm_cnt;
      endcase
    end
  end

  assign tt.uio_out = dbg_q;
  assign tt.uio_oe  = oe_q;
  assign unused_ok  = &{1'b0, tt.ena, tt.uio_in};
`else
  logic unused_ok;

  assign tt.uio_out = 8'h00;
  assign tt.uio_oe  = 8'h00;
  assign unused_ok  = &{1'b0, tt.ena, tt.uio_in, tt.ui_in[7:6]};
`endif

endmodule

// File: tb/tb_rgb_mixer.sv
// Bench for rgb_mixer. It drives encoder pulses, keeps a saturating level model,
// and queues the expected duty counts for each channel. It measures the duty of
// each PWM output over a 256-clock window and compares it with the queue head.
module tb_rgb_mixer;
  localparam int W = 32;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ui;
  int          checks;
  int          errors;
  int          edge_n;
  int          exp_lvl [3];
  logic [2:0]  cur_b;
  logic [W-1:0] exp_q[$];

  rgb_mixer_if tt ();

  assign tt.ena    = 1'b1;
  assign tt.uio_in = 8'h00;
  assign tt.ui_in  = ui;

  rgb_mixer #(.DEBOUNCE_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt)
  );

  // Clock and edge counter since the last reset release
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (edge_n != target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("edge_wait", edge_n, target);
  endtask

  // One encoder detent on every channel in chans; down[c] selects decrement.
  task automatic pulse(input logic [2:0] chans, input logic [2:0] down, input int hi, input int lo);
    logic changed;
    changed = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (chans[c]) begin
        if (cur_b[c] != down[c]) changed = 1'b1;
        cur_b[c] = down[c];
        ui[2*c+1] = down[c];
      end
    end
    if (changed) repeat (14) @(negedge clk);
    for (int c = 0; c < 3; c++) if (chans[c]) ui[2*c] = 1'b1;
    repeat (hi) @(negedge clk);
    for (int c = 0; c < 3; c++) if (chans[c]) ui[2*c] = 1'b0;
    repeat (lo) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      if (chans[c]) begin
        if (down[c]) exp_lvl[c] = (exp_lvl[c] > 0)   ? exp_lvl[c] - 1 : 0;
        else         exp_lvl[c] = (exp_lvl[c] < 255) ? exp_lvl[c] + 1 : 255;
      end
    end
  endtask

  task automatic push_expected();
    for (int c = 0; c < 3; c++) exp_q.push_back(exp_lvl[c]);
  endtask

  // Count high cycles over one PWM period and compare against the queued levels.
  task automatic measure(input string tag);
    int cnt [3];
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    repeat (16) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) cnt[c] += int'(tt.uo_out[c]);
    end
    for (int c = 0; c < 3; c++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s_queue%0d", tag, c), 0, 1);
      end else begin
        check($sformatf("%s_duty%0d", tag, c), cnt[c], exp_q.pop_front());
      end
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 3; c++) exp_lvl[c] = 0;
    cur_b = 3'b000;
  endtask

  initial begin
    int idle_hi;
    checks = 0;
    errors = 0;
    clear_model();
    rst_n = 1'b0;
    ui    = 8'h00;

    // Reset held with random encoder activity
    repeat (10) begin
      @(negedge clk);
      ui = 8'($urandom_range(0, 255));
    end
    check("rst_uo_out", tt.uo_out, 8'h00);
    check("rst_uio_oe", tt.uio_oe, 8'h00);
    check("rst_uio_out", tt.uio_out, 8'h00);
    ui = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: no output activity for 1024 clocks
    idle_hi = 0;
    repeat (1024) begin
      @(negedge clk);
      idle_hi += int'(tt.uo_out[0]) + int'(tt.uo_out[1]) + int'(tt.uo_out[2]);
    end
    check("idle_pwm", idle_hi, 0);

    // Latency: A is first sampled at edge 1270, so the level becomes 1 at edge 1280.
    // pwm0 goes high at edge 1281, where pwm_cnt is 1280 mod 256 = 0.
    wait_edge(1269);
    ui[0] = 1'b1;
    wait_edge(1280);
    check("lat_pwm_before", tt.uo_out[0], 1'b0);
    @(negedge clk);
    check("lat_pwm_first", tt.uo_out[0], 1'b1);

    // Reset mid-operation clears the outputs without a clock
    rst_n = 1'b0;
    #1;
    check("midrst_uo_out", tt.uo_out, 8'h00);
    ui = 8'h00;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Increment: 64 clean pulses on enc0
    for (int i = 0; i < 64; i++) pulse(3'b001, 3'b000, 20, 20);
    push_expected();
    measure("inc");

    // Saturation on enc1: up past the top, 10 down, then down past zero
    for (int i = 0; i < 300; i++) pulse(3'b010, 3'b000, 14, 14);
    push_expected();
    measure("sat_hi");
    for (int i = 0; i < 10; i++) pulse(3'b010, 3'b010, 14, 14);
    push_expected();
    measure("sat_dn10");
    for (int i = 0; i < 300; i++) pulse(3'b010, 3'b010, 14, 14);
    push_expected();
    measure("sat_lo");

    // Glitch of 5 clocks on enc2_a must be rejected
    ui[4] = 1'b1;
    repeat (5) @(negedge clk);
    ui[4] = 1'b0;
    repeat (20) @(negedge clk);
    push_expected();
    measure("glitch");

    // Glitch of 7 clocks, one short of the window, must also be rejected
    ui[4] = 1'b1;
    repeat (7) @(negedge clk);
    ui[4] = 1'b0;
    repeat (20) @(negedge clk);
    push_expected();
    measure("glitch7");

    // Simultaneous detents: ch0 down, ch1 up, ch2 up
    pulse(3'b111, 3'b001, 14, 14);
    pulse(3'b111, 3'b001, 14, 14);
    push_expected();
    measure("simul");

`ifdef RGB_MIXER_DEBUG_EN
    for (int s = 0; s < 3; s++) begin
      ui[7:6] = 2'(s);
      repeat (3) @(negedge clk);
      check($sformatf("dbg_level%0d", s), tt.uio_out, exp_lvl[s]);
      check("dbg_oe", tt.uio_oe, 8'hFF);
    end
`else
    check("nodbg_uio_out", tt.uio_out, 8'h00);
    check("nodbg_uio_oe", tt.uio_oe, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_mixer.md
# rgb_mixer

Three-channel RGB LED mixer tile. Three quadrature rotary encoders on `ui_in` each set an 8-bit brightness level. Each level drives one PWM output on `uo_out[2:0]`. The block is the top of a Tiny Tapeout user tile and uses the standard tile pinout.

## Interface
Parameters:
- `DEBOUNCE_LEN`, default 8: number of consecutive equal synchronized samples needed before a debounced encoder line changes (range 2–16).

Ports:
- `clk` input 1: tile clock; all logic is on the rising edge.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `ena` input 1: tile-selected flag. It is ignored; the logic runs whenever clocked.
- `ui_in` input 8: encoder lines.
  - `[0]` enc0_a, `[1]` enc0_b, `[2]` enc1_a, `[3]` enc1_b, `[4]` enc2_a, `[5]` enc2_b.
  - `[7:6]` are unused.
- `uo_out` output 8: `[0]` pwm0, `[1]` pwm1, `[2]` pwm2. `[7:3]` are held at 0.
- `uio_in` input 8: unused.
- `uio_out` output 8: debug bus (see Configuration).
- `uio_oe` output 8: bidirectional pin enables (see Configuration).

## Operation
Each of the three channels is an identical slice:
- **Synchronizer:** each A/B line goes through a 2-flop synchronizer (`s1`→`s2`).
- **Debounce:**
  - A `DEBOUNCE_LEN`-bit shift register shifts in `s2` every clock.
  - The registered debounced line takes the shifted-in value on the clock after all bits are equal.
  - Otherwise it holds its value.
- **Decode (x1):**
  - A rising edge is detected when the debounced A is 1 and its 1-cycle-delayed copy is 0.
  - On a rising edge with debounced B = 0, the level increments.
  - On a rising edge with debounced B = 1, the level decrements.
  - A falling edge of A and any change of B have no effect.
- **Level:**
  - The level is an 8-bit register that saturates.
  - Incrementing at 255 stays at 255; decrementing at 0 stays at 0.
- **PWM:**
  - One free-running 8-bit counter `pwm_cnt` is shared by all channels. It wraps 255→0 and has a period of 256 clocks.
  - Each output is registered: `pwm_n <= (pwm_cnt < level_n)`.
  - Level 0 gives a constant 0.
  - Level L gives a duty cycle of L/256. Level 255 is high for 255 of every 256 cycles.
- The channels are fully independent. Simultaneous activity on several encoders updates each level in the same cycle.

## Timing
Reset values (`rst_n` = 0, asynchronous):
- Synchronizers, shift registers, debounced lines and delayed copies are all 0.
- Levels are 0 and `pwm_cnt` is 0.
- `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0x00.

Latency, with clock edge 1 being the first edge that samples the new A value:
- `s2` updates at edge 2.
- The shift register is all-equal at edge 1+`DEBOUNCE_LEN`.
- The debounced line updates at edge 2+`DEBOUNCE_LEN`.
- The level updates at edge 3+`DEBOUNCE_LEN`. This is edge 11 for the default.
- A PWM output reflects a new level on the edge after the level changes.

Debounce boundary cases:
- A glitch shorter than `DEBOUNCE_LEN` clocks is rejected.
- A B line must be stable at least as long as the same A edge is being debounced.

Other boundary cases:
- If B changes at the same time as A, the new B is used only if its debounced value is already settled at the decode edge.
- Reset asserted mid-operation clears all state immediately.
- After reset deasserts, `pwm_cnt` starts from 0 on the first edge.

## Configuration
Macro `RGB_MIXER_DEBUG_EN`:
- **Defined:**
  - `uio_oe` = 0xFF.
  - `uio_out` shows the level of the channel chosen by `ui_in[7:6]`: 0 → level0, 1 → level1, 2 → level2, 3 → `pwm_cnt`.
  - The value is registered, so it has 1 cycle of latency.
- **Undefined:** `uio_out` = 0x00 and `uio_oe` = 0x00 at all times.

## Test plan
- **Reset:** hold `rst_n` = 0 for 10 clocks with random `ui_in` → `uo_out` = 0x00 and `uio_oe` = 0x00. After release with no encoder activity, pwm0–2 stay 0 for 1024 clocks.
- **Increment:** 64 clean enc0 pulses with B = 0 (A high 20 clocks, low 20 clocks) → pwm0 is high for exactly 64 of 256 cycles; pwm1 and pwm2 stay 0.
- **Saturation:** 300 increments on enc1 → pwm1 is high for 255 of 256 cycles. Then 10 decrements (B = 1) → 245 of 256. Then 300 decrements → 0 of 256.
- **Glitch rejection:** a 5-clock high pulse on enc2_a (below `DEBOUNCE_LEN` = 8) → level2 is unchanged and pwm2 stays 0.
- **Latency:** enc0_a rises with enc0_b = 0 and held → level0 changes 0→1 exactly at edge 11; pwm0 is first high when `pwm_cnt` = 0.
- **Debug (with `RGB_MIXER_DEBUG_EN`):** set levels to 3/7/9 and step `ui_in[7:6]` through 0–2 → `uio_out` = 3, 7, 9, with `uio_oe` = 0xFF.
